// File: rtl/id_ex_stage.sv
// ID/EX stage: instruction decode, register-file read with writeback bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_writereg,
  input  logic [31:0] wb_writedata,
  input  logic        ex_flush,
  input  logic        ex_hold,
  output logic        id_stall,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_alusrc,
  output logic        ex_regdst,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [1:0]  ex_aluop,
  output logic [31:0] ex_rdata1,
  output logic [31:0] ex_rdata2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc4
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        regdst;
    logic        branch;
    logic        jump;
    logic [1:0]  aluop;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } idex_t;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_used;
  logic        rt_used;
  logic [31:0] opnd1;
  logic [31:0] opnd2;
  logic        load_use;
  idex_t       dec;
  idex_t       q;

  assign opcode     = if_instr[31:26];
  assign rs         = if_instr[25:21];
  assign rt         = if_instr[20:16];
  assign rf_rs_addr = rs;
  assign rf_rt_addr = rt;

  // Same-cycle writeback bypass; register 0 is hardwired and never bypassed.
  assign opnd1 = (wb_regwrite && (wb_writereg != '0) && (wb_writereg == rs)) ? wb_writedata : rf_rdata1;
  assign opnd2 = (wb_regwrite && (wb_writereg != '0) && (wb_writereg == rt)) ? wb_writedata : rf_rdata2;

  // Main control decode plus which source registers the instruction reads.
  always_comb begin
    dec     = '0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        dec.regdst   = 1'b1;
        dec.aluop    = 2'b10;
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      OP_LW: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        rs_used      = 1'b1;
      end
      OP_SW: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        rs_used      = 1'b1;
        rt_used      = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        rs_used    = 1'b1;
        rt_used    = 1'b1;
      end
      OP_ADDI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        rs_used      = 1'b1;
      end
      OP_J: begin
        dec.jump = 1'b1;
      end
      default: ;
    endcase
    dec.valid  = 1'b1;
    dec.rdata1 = opnd1;
    dec.rdata2 = opnd2;
    dec.imm    = {{16{if_instr[15]}}, if_instr[15:0]};
    dec.rs     = rs;
    dec.rt     = rt;
    dec.rd     = if_instr[15:11];
    dec.pc4    = if_pc4;
  end

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = q.valid && q.memread && (q.rt != '0) && if_valid &&
                    ((rs_used && (q.rt == rs)) || (rt_used && (q.rt == rt)));

  assign id_stall = load_use || ex_hold;

  // ID/EX register: flush beats hold; a load-use or empty slot becomes a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    q <= '0;
    else if (ex_flush)             q <= '0;
    else if (ex_hold)              q <= q;
    else if (load_use || !if_valid) q <= '0;
    else                           q <= dec;
  end

  assign ex_valid    = q.valid;
  assign ex_regwrite = q.regwrite;
  assign ex_memread  = q.memread;
  assign ex_memwrite = q.memwrite;
  assign ex_memtoreg = q.memtoreg;
  assign ex_alusrc   = q.alusrc;
  assign ex_regdst   = q.regdst;
  assign ex_branch   = q.branch;
  assign ex_jump     = q.jump;
  assign ex_aluop    = q.aluop;
  assign ex_rdata1   = q.rdata1;
  assign ex_rdata2   = q.rdata2;
  assign ex_imm      = q.imm;
  assign ex_rs       = q.rs;
  assign ex_rt       = q.rt;
  assign ex_rd       = q.rd;
  assign ex_pc4      = q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected ID/EX contents,
// a monitor pops and compares after every rising edge.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_regwrite;
  logic [4:0]  wb_writereg;
  logic [31:0] wb_writedata;
  logic        ex_flush, ex_hold, id_stall;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic        ex_alusrc, ex_regdst, ex_branch, ex_jump;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
    .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_aluop(ex_aluop),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_pc4(ex_pc4)
  );

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;  // regwrite,memread,memwrite,memtoreg,alusrc,regdst,branch,jump,aluop[1:0]
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } rec_t;

  localparam logic [31:0] ADD   = 32'h012A4020;  // add $8,$9,$10
  localparam logic [31:0] ADDI0 = 32'h20080004;  // addi $8,$0,4
  localparam logic [31:0] LW9   = 32'h8C090000;  // lw $9,0($0)
  localparam logic [31:0] LW0   = 32'h8C000000;  // lw $0,0($0)

  rec_t q[$];
  rec_t m;
  int   tests = 0;
  int   fails = 0;

  function automatic rec_t act();
    return {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
            ex_regdst, ex_branch, ex_jump, ex_aluop, ex_rdata1, ex_rdata2, ex_imm,
            ex_rs, ex_rt, ex_rd, ex_pc4};
  endfunction

  // Control table straight from the opcode list.
  function automatic logic [9:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b10000100_10;
      6'h23:   return 10'b11011000_00;
      6'h2B:   return 10'b00101000_00;
      6'h04:   return 10'b00000010_01;
      6'h08:   return 10'b10001000_00;
      6'h02:   return 10'b00000001_00;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic rs_used(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
  endfunction

  function automatic logic rt_used(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04};
  endfunction

  task automatic check(input string name, input logic [159:0] a, input logic [159:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic v, input logic [31:0] r1, r2,
                      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                      input logic fl, input logic ho);
    rec_t nx;
    logic lu;
    logic [4:0] rs, rt;
    logic [5:0] op;
    logic [31:0] b1, b2, pc;
    @(negedge clk);
    pc = $urandom;
    if_instr = instr; if_valid = v; if_pc4 = pc; rf_rdata1 = r1; rf_rdata2 = r2;
    wb_regwrite = wbw; wb_writereg = wbr; wb_writedata = wbd; ex_flush = fl; ex_hold = ho;
    #1;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
    lu = m.valid && m.ctrl[8] && (m.rt != 0) && v &&
         ((rs_used(op) && m.rt == rs) || (rt_used(op) && m.rt == rt));
    check("rs_addr", rf_rs_addr, rs);
    check("rt_addr", rf_rt_addr, rt);
    check("id_stall", id_stall, lu || ho);
    b1 = (wbw && wbr != 0 && wbr == rs) ? wbd : r1;
    b2 = (wbw && wbr != 0 && wbr == rt) ? wbd : r2;
    if (fl)            nx = '0;
    else if (ho)       nx = m;
    else if (lu || !v) nx = '0;
    else nx = {1'b1, ctrl_of(op), b1, b2, {{16{instr[15]}}, instr[15:0]}, rs, rt, instr[15:11], pc};
    q.push_back(nx);
    m = nx;
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare ID/EX contents after each edge against the scoreboard.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("idex", act(), e);
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [31:0] ins;
    m = '0;
    reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc4 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    wb_regwrite = 1'b0; wb_writereg = '0; wb_writedata = '0; ex_flush = 1'b0; ex_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", act(), 0);
    check("reset_stall", id_stall, 0);
    @(negedge clk) reset = 1'b1;

    step(ADD, 1, 5, 7, 0, 0, 0, 0, 0); post();
    check("add_rdata1", ex_rdata1, 5);
    check("add_rdata2", ex_rdata2, 7);
    check("add_rd", ex_rd, 8);
    check("add_aluop", ex_aluop, 2'b10);
    check("add_regdst", {ex_regwrite, ex_regdst}, 2'b11);
    step(ADD, 1, 5, 7, 1, 9, 32'hDEAD, 0, 0); post();
    check("bypass_rs", ex_rdata1, 32'hDEAD);
    step(ADD, 1, 5, 7, 1, 0, 32'hDEAD, 0, 0); post();
    check("bypass_r0_add", ex_rdata1, 5);
    step(ADDI0, 1, 3, 0, 1, 0, 32'hBEEF, 0, 0); post();
    check("bypass_r0", ex_rdata1, 3);

    step(LW9, 1, 0, 0, 0, 0, 0, 0, 0);
    step(ADD, 1, 1, 2, 0, 0, 0, 0, 0); post();
    check("loaduse_bubble", ex_valid, 0);
    step(ADD, 1, 1, 2, 0, 0, 0, 0, 0); post();
    check("loaduse_resume", ex_valid, 1);
    step(LW0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(ADDI0, 1, 0, 0, 0, 0, 0, 0, 0); post();
    check("lw0_nostall", ex_valid, 1);

    step(ADD, 1, 1, 2, 0, 0, 0, 0, 0);
    step(ADD, 1, 1, 2, 0, 0, 0, 1, 1); post();
    check("flush_hold", ex_valid, 0);
    step(ADD, 1, 11, 22, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(ADDI0, 1, 9, 9, 0, 0, 0, 0, 1); post();
      check("hold_keep", ex_rdata1, 11);
    end

    step(32'h8C09FFFC, 1, 0, 0, 0, 0, 0, 0, 0); post();
    check("lw_imm", ex_imm, 32'hFFFFFFFC);
    check("lw_ctl", {ex_alusrc, ex_memtoreg}, 2'b11);
    step(32'hFC000000, 1, 0, 0, 0, 0, 0, 0, 0); post();
    check("unk_ctl", {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                      ex_regdst, ex_branch, ex_jump, ex_aluop}, 11'b1_00000000_00);

    // Asynchronous reset while a load sits in ID/EX and a stall is pending.
    step(LW9, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if_instr = ADD; if_valid = 1'b1;
    #1;
    check("pre_reset_stall", id_stall, 1);
    #1 reset = 1'b0;
    #1;
    check("async_reset", act(), 0);
    check("async_reset_stall", id_stall, 0);
    m = '0;
    q.push_back('0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'($urandom_range(0, 63))};
      ins = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             16'($urandom)};
      step(ins, ($urandom_range(0, 7) != 0), $urandom, $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute stage of the five-stage MIPS pipeline. Takes the IF/ID instruction and drives the register file read addresses. It merges the register file read data with a same-cycle writeback bypass, decodes the main control bits, and registers everything into the ID/EX pipeline register. It also detects load-use hazards: it stalls IF/ID and inserts a bubble. It accepts branch flushes and downstream holds.

## Interface
- No parameters; datapath fixed at 32 bits, register addresses 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears ID/EX register immediately
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  32  instruction from IF/ID
- if_pc4  in  32  PC+4 from IF/ID
- rf_rs_addr  out  5  = if_instr[25:21], to register file ReadReg1 (combinational)
- rf_rt_addr  out  5  = if_instr[20:16], to register file ReadReg2 (combinational)
- rf_rdata1, rf_rdata2  in  32  register file ReadData1/ReadData2
- wb_regwrite  in  1  writeback stage writing this cycle
- wb_writereg  in  5  writeback destination
- wb_writedata  in  32  writeback data
- ex_flush  in  1  branch/jump taken: squash instruction entering EX
- ex_hold  in  1  downstream stall: freeze ID/EX contents
- id_stall  out  1  to IF/ID and PC: hold current instruction (combinational)
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst, ex_branch, ex_jump  out  1 each  registered control
- ex_aluop  out  2  00 add, 01 sub, 10 funct-decoded
- ex_rdata1, ex_rdata2  out  32  registered operands (post-bypass)
- ex_imm  out  32  sign-extended if_instr[15:0]
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields
- ex_pc4  out  32  registered PC+4

## Operation
- Decode on opcode if_instr[31:26]. Control bits are regwrite/memread/memwrite/memtoreg/alusrc/regdst/branch/jump, with aluop last:
  - 000000 R-type: 1/0/0/0/0/1/0/0, aluop 10.
  - 100011 lw: 1/1/0/1/1/0/0/0, aluop 00.
  - 101011 sw: 0/0/1/0/1/0/0/0, aluop 00.
  - 000100 beq: branch=1, aluop 01, all others 0.
  - 001000 addi: regwrite=1, alusrc=1, aluop 00.
  - 000010 j: jump=1 only.
  - Any other opcode: all control 0; ex_valid still follows if_valid.
- Source usage: rs is used by R-type, lw, sw, beq and addi. rt is used by R-type, sw and beq. j uses neither.
- Bypass: if wb_regwrite=1, wb_writereg≠0 and wb_writereg==rs, then the operand is wb_writedata, else rf_rdata1. Same rule for rt with rf_rdata2. Register 0 is never bypassed.
- Load-use hazard: load_use = ex_valid & ex_memread & (ex_rt≠0) & if_valid & ((rs used & ex_rt==rs) | (rt used & ex_rt==rt)).
- id_stall = load_use | ex_hold.
- Per-edge priority (highest first):
  1. reset low: register cleared.
  2. ex_flush: bubble loaded.
  3. ex_hold: register keeps value.
  4. load_use: bubble loaded.
  5. Otherwise: load decoded instruction.
- Bubble: ex_valid and all control 0, every data/address field 0.
- if_valid=0 loads a bubble.

## Timing
- Reset (async assert, any time, including mid-stall): every output register 0. ex_aluop=00. id_stall then depends only on inputs (0 after reset, since ex_valid=0).
- Latency: one cycle IF/ID → EX. Read addresses, bypass mux and id_stall are combinational in the same cycle.
- A load-use stall lasts exactly one cycle. After the bubble, ex_memread=0, so id_stall drops and the held instruction loads on the next edge. Operands come via WB bypass or the MEM forwarding handled in EX.
- ex_flush together with ex_hold: flush wins, bubble loaded.
- ex_flush together with load_use: bubble loaded; id_stall still asserted that cycle, and IF/ID handles its own flush.
- Deassertion of reset is synchronous to the next clk edge by design of upstream reset logic; no additional requirement here.

## Test plan
- Reset: assert reset=0 mid-cycle while ID/EX holds an lw → all outputs 0 immediately, id_stall=0.
- Normal R-type: if_instr=0x012A4020 (add $8,$9,$10), rf_rdata1=5, rf_rdata2=7 → next edge: ex_regwrite=1, ex_regdst=1, ex_aluop=10, ex_rdata1=5, ex_rdata2=7, ex_rd=8.
- WB bypass: same add with wb_regwrite=1, wb_writereg=9, wb_writedata=0xDEAD → ex_rdata1=0xDEAD. Repeat with wb_writereg=0 → rf_rdata1 kept.
- Load-use: ID/EX holds lw $9 while IF/ID has add $8,$9,$10 → id_stall=1, next edge bubble (ex_valid=0). Following edge: the add loads, id_stall=0. Also, addi $8,$0,4 after lw $0 → no stall.
- Flush vs hold: ex_flush=1, ex_hold=1 with valid add → bubble. ex_hold=1 alone → ID/EX unchanged for 3 cycles, id_stall=1 throughout.
- Immediate: lw with imm 0xFFFC → ex_imm=0xFFFFFFFC, ex_alusrc=1, ex_memtoreg=1. Unknown opcode 0x3F → all control 0, ex_valid=1.
